// File: rtl/fwd_wb_pipe_pkg.sv
// Shared defaults and packet shape for the forward/writeback pipeline.
package fwd_wb_pipe_pkg;

  localparam int unsigned DEF_DATA_W = 128;
  localparam int unsigned DEF_ADDR_W = 7;
  localparam int unsigned DEF_UNIT_W = 3;

  // Default-width packet; the top derives its own copy when widths are overridden.
  typedef struct packed {
    logic                  valid;
    logic [DEF_UNIT_W-1:0] unit;
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } fwd_pkt_t;

endpackage

// File: rtl/fwd_lane_pipe.sv
// One issue lane's result shift pipeline: insert at a given stage, flush of young
// stages, and detection of inserts that overwrite a live packet.
module fwd_lane_pipe
  import fwd_wb_pipe_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned FLUSH_BOUND = 3,
  parameter type         pkt_t       = fwd_pkt_t
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         ins_valid,
  input  logic [$clog2(DEPTH + 1)-1:0] ins_lat,
  input  pkt_t                         ins_pkt,
  output pkt_t [DEPTH-1:0]             stages,
  output logic                         collision
);

  localparam int unsigned LAT_W = $clog2(DEPTH + 1);
  localparam logic [LAT_W-1:0] MaxLat   = LAT_W'(DEPTH);
  localparam logic [LAT_W-1:0] FlushLat = LAT_W'(FLUSH_BOUND);

  pkt_t [DEPTH-1:0] stage_q, stage_d;
  logic             lat_ok, ins_take;

  always_comb begin
    stage_d   = '0;
    collision = 1'b0;
    lat_ok    = (ins_lat != '0) && (ins_lat <= MaxLat);
    ins_take  = ins_valid && lat_ok && !(flush && (ins_lat < FlushLat));
    // Index s holds stage s+1; a flush kills packets leaving stages 1..FLUSH_BOUND-1.
    for (int unsigned s = 1; s < DEPTH; s++) begin
      stage_d[s] = stage_q[s-1];
      if (flush && (s < FLUSH_BOUND)) begin
        stage_d[s].valid = 1'b0;
      end
    end
    for (int unsigned s = 0; s < DEPTH; s++) begin
      if (ins_take && (ins_lat == LAT_W'(s + 1))) begin
        collision  = stage_d[s].valid;
        stage_d[s] = ins_pkt;
      end
    end
    if (ins_valid && !lat_ok) begin
      collision = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stages = stage_q;

endmodule

// File: rtl/fwd_wb_pipe.sv
// Multi-lane result forwarding and register-file writeback pipeline with flush,
// insert-collision and same-cycle retire conflict detection.
module fwd_wb_pipe
  import fwd_wb_pipe_pkg::*;
#(
  parameter int unsigned NUM_LANES   = 2,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned NUM_SRC     = 3,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned UNIT_W      = DEF_UNIT_W,
  parameter int unsigned FLUSH_BOUND = 3
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_LANES-1:0]                     comp_valid,
  input  logic [NUM_LANES*$clog2(DEPTH + 1)-1:0]   comp_lat,
  input  logic [NUM_LANES*UNIT_W-1:0]              comp_unit,
  input  logic [NUM_LANES-1:0]                     comp_we,
  input  logic [NUM_LANES*ADDR_W-1:0]              comp_addr,
  input  logic [NUM_LANES*DATA_W-1:0]              comp_data,
  input  logic                                     flush,
  input  logic [NUM_LANES*NUM_SRC*ADDR_W-1:0]      src_addr,
  input  logic [NUM_LANES*NUM_SRC*DATA_W-1:0]      src_rf_data,
  output logic [NUM_LANES*NUM_SRC*DATA_W-1:0]      src_fwd_data,
  output logic [NUM_LANES*NUM_SRC-1:0]             src_fwd_hit,
  output logic [NUM_LANES-1:0]                     rf_we,
  output logic [NUM_LANES*ADDR_W-1:0]              rf_waddr,
  output logic [NUM_LANES*DATA_W-1:0]              rf_wdata,
  output logic                                     collision_err,
  output logic                                     waw_err
);

  localparam int unsigned LAT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic [UNIT_W-1:0] unit;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } lane_pkt_t;

  lane_pkt_t                 ins_pkt [NUM_LANES];
  lane_pkt_t [DEPTH-1:0]     lane_st [NUM_LANES];
  logic      [NUM_LANES-1:0] lane_coll;
  logic      [NUM_LANES-1:0] ret_we;
  logic                      waw_hit;
  logic                      coll_q, waw_q;
  logic                      unused_unit;

  always_comb begin
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      ins_pkt[l].valid = 1'b1;
      ins_pkt[l].unit  = comp_unit[l*UNIT_W +: UNIT_W];
      ins_pkt[l].we    = comp_we[l];
      ins_pkt[l].addr  = comp_addr[l*ADDR_W +: ADDR_W];
      ins_pkt[l].data  = comp_data[l*DATA_W +: DATA_W];
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    fwd_lane_pipe #(
      .DEPTH       (DEPTH),
      .FLUSH_BOUND (FLUSH_BOUND),
      .pkt_t       (lane_pkt_t)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .ins_valid (comp_valid[l]),
      .ins_lat   (comp_lat[l*LAT_W +: LAT_W]),
      .ins_pkt   (ins_pkt[l]),
      .stages    (lane_st[l]),
      .collision (lane_coll[l])
    );
  end

  // Scan oldest stage first and lanes upward so the last match is the youngest result.
  always_comb begin
    src_fwd_data = '0;
    src_fwd_hit  = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        src_fwd_data[(l*NUM_SRC+s)*DATA_W +: DATA_W] =
            src_rf_data[(l*NUM_SRC+s)*DATA_W +: DATA_W];
        for (int st = int'(DEPTH) - 1; st >= 0; st--) begin
          for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (lane_st[k][st].valid && lane_st[k][st].we &&
                (lane_st[k][st].addr == src_addr[(l*NUM_SRC+s)*ADDR_W +: ADDR_W])) begin
              src_fwd_data[(l*NUM_SRC+s)*DATA_W +: DATA_W] = lane_st[k][st].data;
              src_fwd_hit[l*NUM_SRC+s] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    ret_we   = '0;
    rf_waddr = '0;
    rf_wdata = '0;
    waw_hit  = 1'b0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      ret_we[l]                    = lane_st[l][DEPTH-1].valid & lane_st[l][DEPTH-1].we;
      rf_waddr[l*ADDR_W +: ADDR_W] = lane_st[l][DEPTH-1].addr;
      rf_wdata[l*DATA_W +: DATA_W] = lane_st[l][DEPTH-1].data;
    end
    rf_we = ret_we;
    // The youngest lane owns a contested address; older writers are dropped.
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      for (int unsigned h = l + 1; h < NUM_LANES; h++) begin
        if (ret_we[l] && ret_we[h] &&
            (lane_st[l][DEPTH-1].addr == lane_st[h][DEPTH-1].addr)) begin
          rf_we[l] = 1'b0;
          waw_hit  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    unused_unit = 1'b0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      for (int unsigned st = 0; st < DEPTH; st++) begin
        unused_unit = unused_unit ^ (^lane_st[k][st].unit);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coll_q <= 1'b0;
      waw_q  <= 1'b0;
    end else begin
      coll_q <= coll_q | (|lane_coll);
      waw_q  <= waw_q | waw_hit;
    end
  end

  assign collision_err = coll_q;
  assign waw_err       = waw_q;

endmodule

// File: doc/fwd_wb_pipe.md
Name: fwd_wb_pipe

Overview:
- Parametrised successor to the fixed two-pipe forward/writeback path of the SPU core.
- Holds completed results per issue lane in a DEPTH-stage shift pipeline and forwards the youngest matching result to every source operand of every lane.
- Retires the packets leaving the last stage to the register file write ports.
- Adds three things the fixed path lacks: arbitrary lane count, depth and source count; branch flush of young stages; collision and write-conflict detection.

Parameters:
- NUM_LANES, 2, issue lanes (lane 0 = even, lane 1 = odd; a higher lane index is younger in program order).
- DEPTH, 8, pipeline stages per lane; stage DEPTH is the retire stage.
- NUM_SRC, 3, source operands per lane (ra, rb, rc).
- DATA_W, 128, result width (QUADWORD).
- ADDR_W, 7, register address width.
- UNIT_W, 3, unit id width.
- FLUSH_BOUND, 3, a flush kills stages 1..FLUSH_BOUND-1.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  asynchronous, active-low.
- comp_valid  in  NUM_LANES  result completion strobe per lane.
- comp_lat  in  NUM_LANES*$clog2(DEPTH+1)  stage (1..DEPTH) at which the result enters.
- comp_unit  in  NUM_LANES*UNIT_W  producing unit id.
- comp_we  in  NUM_LANES  result writes the register file.
- comp_addr  in  NUM_LANES*ADDR_W  destination register.
- comp_data  in  NUM_LANES*DATA_W  result value.
- flush  in  1  branch mispredict flush.
- src_addr  in  NUM_LANES*NUM_SRC*ADDR_W  operand read addresses.
- src_rf_data  in  NUM_LANES*NUM_SRC*DATA_W  register file read data.
- src_fwd_data  out  NUM_LANES*NUM_SRC*DATA_W  forwarded operand data.
- src_fwd_hit  out  NUM_LANES*NUM_SRC  operand was taken from the pipeline.
- rf_we  out  NUM_LANES  register file write enables.
- rf_waddr  out  NUM_LANES*ADDR_W  register file write addresses.
- rf_wdata  out  NUM_LANES*DATA_W  register file write data.
- collision_err  out  1  sticky insert-collision flag.
- waw_err  out  1  sticky same-cycle retire address conflict flag.

Behaviour:
- Packet = {valid, unit, we, addr, data}. Each lane is a DEPTH-entry shift register; every cycle stage s takes stage s-1. Stage 1 takes a bubble unless a completion inserts there.
- Reset (async, reset=0): every valid bit, rf_we, collision_err and waw_err go to 0; data and addr fields go to 0. Release takes effect at the first posedge after deassertion.
- Insert: comp_valid[l] with comp_lat=L writes the packet into lane l stage L at the next edge. comp_lat=0 or comp_lat>DEPTH is ignored and sets collision_err.
- Collision: if a valid packet is shifting into the same slot, the completion wins, the old packet is dropped, and collision_err is set.
- Retire: stage DEPTH drives rf_we = valid&we, rf_waddr and rf_wdata registered, with 0 cycles of extra latency from the stage register.
- Retire conflict: two lanes retiring the same addr with we=1 in one cycle. Only the highest lane keeps rf_we, the lower lanes are suppressed, and waw_err is set.
- Forwarding (combinational): for each lane/source, search valid&we packets with matching addr.
  - Priority: lowest stage index first (youngest).
  - Same stage: highest lane index wins.
  - The stage DEPTH packet is included.
  - Same-cycle comp_* inputs are not searched.
  - No match: src_fwd_data = src_rf_data and src_fwd_hit = 0.
- Flush: at the edge where flush=1, stages 1..FLUSH_BOUND-1 of all lanes and any same-cycle completions with comp_lat<FLUSH_BOUND become invalid. Stages ≥FLUSH_BOUND shift normally. Flush and insert at comp_lat≥FLUSH_BOUND in the same cycle: the insert is kept.
- Error flags clear only on reset.
- All width arithmetic is unsigned. comp_lat is compared at $clog2(DEPTH+1) bits.

Decomposition:
- Shared package (constants.sv-style): DATA_W/ADDR_W/UNIT_W defaults and a packed typedef fwd_pkt_t {valid, unit, we, addr, data}.
- One sub-module, fwd_lane_pipe: a single lane's shift register with insert, flush and collision detect.
- The top instantiates NUM_LANES copies of fwd_lane_pipe and owns the forwarding priority mux, the retire conflict check and the sticky flags.

Test Plan:
- Reset asserted mid-operation with lanes full → all rf_we=0, flags=0 immediately, no retire after release until new inserts.
- Lane0 insert addr=5, data=0xAA.., comp_lat=2 → visible as src_fwd_hit for addr 5 from the next cycle. rf_we[0]=1, addr 5, data 0xAA.. exactly DEPTH-2 cycles later.
- Forwarding priority:
  - Lane0 stage 4 and lane1 stage 6 both hold addr 9 → lane0 data is forwarded.
  - Lane0 and lane1 both at stage 4 → lane1 data is forwarded.
- Flush with FLUSH_BOUND=3:
  - Packets at stages 1, 2 and 5, flush=1 → only the stage-5 packet ever retires.
  - Same-cycle insert at comp_lat=2 is dropped; insert at comp_lat=3 retires.
- Insert collisions:
  - comp_lat=4 into lane0 while stage 3 holds a valid packet → the new packet retires, the old never does, collision_err=1.
  - comp_lat=0 → collision_err=1.
- Both lanes retire addr 12 with we=1 → rf_we=2'b10, rf_wdata[1] written, waw_err=1 and sticky until reset.
